// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int digitCount(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a one-bit counter.
    function automatic int counterWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor built from chained full subtractors.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic borrowChain;

    always_comb begin
        borrowChain = bi;
        d           = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]        = x[i] ^ y[i] ^ borrowChain;
            borrowChain = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrowChain);
        end
        bo = borrowChain;
    end

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: a - b - bin, DIGIT bits per clock, with valid/ready on both sides.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int NDIG = digitCount(WIDTH, DIGIT);
    localparam int CW   = counterWidth(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadConfig
            $error("serial_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_e           stateQ, stateD;
    logic [WIDTH-1:0] aQ, aD, bQ, bD, diffQ, diffD;
    logic             borrowQ, borrowD;
    logic             borrowOutQ, borrowOutD;
    logic             ovfQ, ovfD;
    logic             aSignQ, aSignD, bSignQ, bSignD;
    logic [CW-1:0]    cntQ, cntD;
    logic             inReadyQ, inReadyD;
    logic             outValidQ, outValidD;

    logic [DIGIT-1:0]       digitD;
    logic                   digitBo;
    logic [WIDTH+DIGIT-1:0] diffShift;

    sub_digit #(.DIGIT(DIGIT)) uDigit (
        .x  (aQ[DIGIT-1:0]),
        .y  (bQ[DIGIT-1:0]),
        .bi (borrowQ),
        .d  (digitD),
        .bo (digitBo)
    );

    // New digits enter at the MSB so the finished word lines up after the last edge.
    assign diffShift = {digitD, diffQ} >> DIGIT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            aQ         <= '0;
            bQ         <= '0;
            diffQ      <= '0;
            borrowQ    <= 1'b0;
            borrowOutQ <= 1'b0;
            ovfQ       <= 1'b0;
            aSignQ     <= 1'b0;
            bSignQ     <= 1'b0;
            cntQ       <= '0;
            inReadyQ   <= 1'b0;
            outValidQ  <= 1'b0;
        end else begin
            stateQ     <= stateD;
            aQ         <= aD;
            bQ         <= bD;
            diffQ      <= diffD;
            borrowQ    <= borrowD;
            borrowOutQ <= borrowOutD;
            ovfQ       <= ovfD;
            aSignQ     <= aSignD;
            bSignQ     <= bSignD;
            cntQ       <= cntD;
            inReadyQ   <= inReadyD;
            outValidQ  <= outValidD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        aD         = aQ;
        bD         = bQ;
        diffD      = diffQ;
        borrowD    = borrowQ;
        borrowOutD = borrowOutQ;
        ovfD       = ovfQ;
        aSignD     = aSignQ;
        bSignD     = bSignQ;
        cntD       = cntQ;
        inReadyD   = inReadyQ;
        outValidD  = outValidQ;

        case (stateQ)
            IDLE: begin
                inReadyD = 1'b1;
                if (in_valid && inReadyQ) begin
                    aD       = a;
                    bD       = b;
                    borrowD  = bin;
                    aSignD   = a[WIDTH-1];
                    bSignD   = b[WIDTH-1];
                    cntD     = '0;
                    inReadyD = 1'b0;
                    stateD   = RUN;
                end
            end
            RUN: begin
                aD      = aQ >> DIGIT;
                bD      = bQ >> DIGIT;
                borrowD = digitBo;
                diffD   = diffShift[WIDTH-1:0];
                cntD    = CW'(cntQ + 1'b1);
                if (cntQ == LAST) begin
                    stateD     = DONE;
                    outValidD  = 1'b1;
                    borrowOutD = digitBo;
                    ovfD       = (aSignQ != bSignQ) && (digitD[DIGIT-1] != aSignQ);
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValidD = 1'b0;
                    inReadyD  = 1'b1;
                    stateD    = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign diff      = diffQ;
    assign borrow    = borrowOutQ;
    assign ovf       = ovfQ;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: 16/4 and 8/8 instances against an arithmetic reference model.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rstN;

    logic        inValid, inReady, bin, outValid, outReady, borrow, ovf;
    logic [15:0] a, b, diff;

    logic        inValid8, inReady8, bin8, outValid8, outReady8, borrow8, ovf8;
    logic [7:0]  a8, b8, diff8;

    int errCount   = 0;
    int checkCount = 0;
    int cycle      = 0;

    typedef struct {
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
        int          acc;
        int          lat;
        bit          seen;
    } txn_t;

    txn_t q16[$];
    txn_t q8[$];

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .bin(bin), .out_valid(outValid), .out_ready(outReady),
        .diff(diff), .borrow(borrow), .ovf(ovf)
    );

    serial_sub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rstN), .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(outValid8), .out_ready(outReady8),
        .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    // Reference: plain integer subtraction of the operands, packed as {ovf, borrow, diff}.
    function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input logic binv);
        longint      mask;
        longint      ua;
        longint      ub;
        longint      full;
        logic [15:0] d;
        logic        br;
        logic        ov;
        mask = (64'sd1 <<< w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        full = ua - ub - longint'(binv);
        d    = 16'(full & mask);
        br   = (ua < ub + longint'(binv));
        ov   = (av[w-1] != bv[w-1]) && (d[w-1] != av[w-1]);
        return {ov, br, d};
    endfunction

    function automatic txn_t mkTxn(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic binv, input int acc, input int lat);
        txn_t        t;
        logic [17:0] m;
        m        = model(w, av, bv, binv);
        t.diff   = m[15:0];
        t.borrow = m[16];
        t.ovf    = m[17];
        t.acc    = acc;
        t.lat    = lat;
        t.seen   = 1'b0;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic getReady(input bit sel);
        return sel ? inReady8 : inReady;
    endfunction

    function automatic logic getValid(input bit sel);
        return sel ? outValid8 : outValid;
    endfunction

    task automatic driveInputs(input bit sel, input logic v, input logic [15:0] av,
                               input logic [15:0] bv, input logic binv);
        if (sel) begin
            inValid8 = v; a8 = av[7:0]; b8 = bv[7:0]; bin8 = binv;
        end else begin
            inValid = v; a = av; b = bv; bin = binv;
        end
    endtask

    task automatic setOutReady(input bit sel, input logic r);
        if (sel) outReady8 = r;
        else     outReady  = r;
    endtask

    // Issue one operand set, wait for the result, optionally stall the consumer, then consume.
    task automatic applyStimulus(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                                 input logic binv, input int hold, input bit earlyReady,
                                 output logic [15:0] gDiff, output logic gBorrow, output logic gOvf);
        int n;
        n = 0;
        while (!getReady(sel) && n < 20) begin tick(); n++; end
        checkOutput("inReadyWait", 32'(getReady(sel)), 32'd1);
        setOutReady(sel, earlyReady);
        driveInputs(sel, 1'b1, av, bv, binv);
        tick();
        driveInputs(sel, 1'b0, ~av, ~bv, ~binv);
        n = 0;
        while (!getValid(sel) && n < 20) begin tick(); n++; end
        checkOutput("outValidWait", 32'(getValid(sel)), 32'd1);
        gDiff   = sel ? {8'h00, diff8} : diff;
        gBorrow = sel ? borrow8 : borrow;
        gOvf    = sel ? ovf8 : ovf;
        for (int k = 0; k < hold; k++) begin
            driveInputs(sel, 1'(k % 2 == 0), av + 16'h1111 * 16'(k + 1), bv, binv);
            tick();
        end
        driveInputs(sel, 1'b0, av, bv, binv);
        setOutReady(sel, 1'b1);
        tick();
        setOutReady(sel, 1'b0);
        checkOutput("consumeValid", 32'(getValid(sel)), 32'd0);
        checkOutput("consumeReady", 32'(getReady(sel)), 32'd1);
    endtask

    // Accepts are recorded from the handshake; expectations come from the model.
    always @(posedge clk) begin
        cycle++;
        if (!rstN) begin
            q16.delete();
            q8.delete();
        end else begin
            if (inValid && inReady)   q16.push_back(mkTxn(16, a, b, bin, cycle, 4));
            if (inValid8 && inReady8) q8.push_back(mkTxn(8, {8'h00, a8}, {8'h00, b8}, bin8, cycle, 1));
        end
    end

    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (q16.size() > 0) checkOutput("busyReady16", 32'(inReady), 32'd0);
            if (outValid === 1'b1) begin
                if (q16.size() == 0) begin
                    checkOutput("spuriousValid16", 32'(outValid), 32'd0);
                end else begin
                    checkOutput("diff16", 32'(diff), 32'(q16[0].diff));
                    checkOutput("borrow16", 32'(borrow), 32'(q16[0].borrow));
                    checkOutput("ovf16", 32'(ovf), 32'(q16[0].ovf));
                    if (!q16[0].seen) begin
                        checkOutput("latency16", 32'(cycle - q16[0].acc), 32'(q16[0].lat));
                        q16[0].seen = 1'b1;
                    end
                    if (outReady) void'(q16.pop_front());
                end
            end
            if (q8.size() > 0) checkOutput("busyReady8", 32'(inReady8), 32'd0);
            if (outValid8 === 1'b1) begin
                if (q8.size() == 0) begin
                    checkOutput("spuriousValid8", 32'(outValid8), 32'd0);
                end else begin
                    checkOutput("diff8", 32'(diff8), 32'(q8[0].diff));
                    checkOutput("borrow8", 32'(borrow8), 32'(q8[0].borrow));
                    checkOutput("ovf8", 32'(ovf8), 32'(q8[0].ovf));
                    if (!q8[0].seen) begin
                        checkOutput("latency8", 32'(cycle - q8[0].acc), 32'(q8[0].lat));
                        q8[0].seen = 1'b1;
                    end
                    if (outReady8) void'(q8.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] gDiff;
        logic        gBorrow, gOvf;

        rstN = 1'b0;
        driveInputs(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        driveInputs(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        outReady  = 1'b0;
        outReady8 = 1'b0;
        repeat (3) tick();

        checkOutput("rstInReady", 32'(inReady), 32'd0);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstDiff", 32'(diff), 32'd0);
        checkOutput("rstBorrow", 32'(borrow), 32'd0);
        checkOutput("rstOvf", 32'(ovf), 32'd0);
        checkOutput("rstInReady8", 32'(inReady8), 32'd0);
        rstN = 1'b1;
        tick();
        checkOutput("readyAfterRst", 32'(inReady), 32'd1);
        checkOutput("readyAfterRst8", 32'(inReady8), 32'd1);

        checkOutput("modelPin1", 32'(model(16, 16'h1234, 16'h0034, 1'b0)), 32'h01200);
        checkOutput("modelPin2", 32'(model(16, 16'h8000, 16'h0001, 1'b0)), 32'h27FFF);
        checkOutput("modelPin3", 32'(model(16, 16'h7FFF, 16'hFFFF, 1'b0)), 32'h38000);
        checkOutput("modelPin4", 32'(model(8, 16'h0000, 16'h0080, 1'b0)), 32'h30080);

        applyStimulus(1'b0, 16'h1234, 16'h0034, 1'b0, 0, 1'b0, gDiff, gBorrow, gOvf);
        checkOutput("t1Diff", 32'(gDiff), 32'h1200);
        checkOutput("t1Flags", 32'({gBorrow, gOvf}), 32'b00);

        applyStimulus(1'b0, 16'h0000, 16'h0001, 1'b0, 0, 1'b1, gDiff, gBorrow, gOvf);
        checkOutput("t2Diff", 32'(gDiff), 32'hFFFF);
        checkOutput("t2Flags", 32'({gBorrow, gOvf}), 32'b10);

        applyStimulus(1'b0, 16'h8000, 16'h0001, 1'b0, 0, 1'b0, gDiff, gBorrow, gOvf);
        checkOutput("t3Diff", 32'(gDiff), 32'h7FFF);
        checkOutput("t3Flags", 32'({gBorrow, gOvf}), 32'b01);

        applyStimulus(1'b0, 16'h0005, 16'h0005, 1'b1, 0, 1'b0, gDiff, gBorrow, gOvf);
        checkOutput("t4Diff", 32'(gDiff), 32'hFFFF);
        checkOutput("t4Flags", 32'({gBorrow, gOvf}), 32'b10);

        applyStimulus(1'b0, 16'h7FFF, 16'hFFFF, 1'b0, 3, 1'b0, gDiff, gBorrow, gOvf);
        checkOutput("t5Diff", 32'(gDiff), 32'h8000);
        checkOutput("t5Flags", 32'({gBorrow, gOvf}), 32'b11);

        // Reset lands on the second RUN cycle of an in-flight subtraction.
        driveInputs(1'b0, 1'b1, 16'hABCD, 16'h1111, 1'b0);
        tick();
        driveInputs(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("midRstInReady", 32'(inReady), 32'd0);
        checkOutput("midRstOutValid", 32'(outValid), 32'd0);
        checkOutput("midRstDiff", 32'(diff), 32'd0);
        checkOutput("midRstFlags", 32'({borrow, ovf}), 32'b00);
        tick();
        checkOutput("midRstReadyBack", 32'(inReady), 32'd1);

        applyStimulus(1'b0, 16'h0010, 16'h0001, 1'b0, 0, 1'b0, gDiff, gBorrow, gOvf);
        checkOutput("t6Diff", 32'(gDiff), 32'h000F);
        checkOutput("t6Flags", 32'({gBorrow, gOvf}), 32'b00);

        applyStimulus(1'b1, 16'h0000, 16'h0080, 1'b0, 0, 1'b0, gDiff, gBorrow, gOvf);
        checkOutput("t7Diff", 32'(gDiff), 32'h0080);
        checkOutput("t7Flags", 32'({gBorrow, gOvf}), 32'b11);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
